// File: rtl/image_xform_engine.sv
// ----------------------------------------------------------------------------
// image_xform_engine
//
// Multi-channel burst-based image transform engine. For each frame it walks
// the output raster in bursts of BURST_LEN words. Each burst's source burst is
// read from the channel's source buffer into a local buffer, and then written
// to the channel's destination buffer. Channels are served round-robin. Each
// channel has a ping-pong flag that swaps its A/B buffers after every frame.
//
// Ports
//   clk, rst            memory clock, asynchronous active-low reset
//   mode                0 PASS, 1 XSHIFT, 2 YSHIFT, 3 HMIRROR, 4 VMIRROR
//                       (5-7 behave as PASS)
//   x_shift, y_shift    signed word / row shifts, latched once per frame
//   rd_*                read burst master interface
//   wr_*                write burst master interface
//   cur_ch              channel currently being processed
//   frame_done          one-cycle pulse after the last burst of a frame
//   error               sticky protocol error flag
//
// Configuration
//   IMG_XFORM_BORDER_EN  when defined, every word on the frame perimeter is
//                        forced to all-ones.
// ----------------------------------------------------------------------------
module image_xform_engine #(
    parameter int MEM_DATA_LEN = 64,
    parameter int ADDR_LEN     = 32,
    parameter int VIDEO_WIDTH  = 960,
    parameter int VIDEO_HEIGHT = 540,
    parameter int BURST_LEN    = 8,
    parameter int N_CH         = 4,
    parameter int CH_BASE      = 0,
    parameter int CH_STRIDE    = 8388608,
    parameter logic [MEM_DATA_LEN-1:0] FILL_COLOR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              mode,
    input  logic [11:0]             x_shift,
    input  logic [11:0]             y_shift,
    output logic                    rd_valid,
    output logic [ADDR_LEN-1:0]     rd_addr,
    output logic [9:0]              rd_burst_len,
    input  logic                    rd_data_valid,
    input  logic [MEM_DATA_LEN-1:0] rd_data,
    input  logic                    rd_burst_finish,
    output logic                    wr_valid,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [9:0]              wr_burst_len,
    input  logic                    wr_data_req,
    output logic [MEM_DATA_LEN-1:0] wr_data,
    input  logic                    wr_burst_finish,
    output logic [2:0]              cur_ch,
    output logic                    frame_done,
    output logic                    error
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // One spare bit so an over-long read burst cannot wrap back to BURST_LEN.
    localparam int CNT_W = $clog2(BURST_LEN + 1) + 1;
    localparam logic signed [13:0] W_S = 14'(VIDEO_WIDTH);
    localparam logic signed [13:0] H_S = 14'(VIDEO_HEIGHT);
    localparam logic signed [13:0] B_S = 14'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, LATCH, READ, SKIP, WRITE, NEXT} state_t;

    state_t                  state;
    logic [2:0]              mode_lat;
    logic signed [13:0]      xs_lat;
    logic signed [13:0]      ys_lat;
    logic [13:0]             row;
    logic [13:0]             col;
    logic [7:0]              ping;
    logic                    skip_burst;
    logic [CNT_W-1:0]        rd_cnt;
    logic [IDX_W-1:0]        idx;
    logic [MEM_DATA_LEN-1:0] buffer [BURST_LEN];

    assign rd_burst_len = 10'(BURST_LEN);
    assign wr_burst_len = 10'(BURST_LEN);

    // Shift inputs widened to 14 bit. The low bits of x_shift are dropped, so a
    // burst is never split across the edge of the source image.
    logic        [2:0]  mode_in;
    logic signed [13:0] xs_in;
    logic signed [13:0] ys_in;
    assign mode_in = (mode > 3'd4) ? 3'd0 : mode;
    assign xs_in   = {{2{x_shift[11]}}, x_shift} & ~14'(BURST_LEN - 1);
    assign ys_in   = {{2{y_shift[11]}}, y_shift};

    // Raster position of the following burst, and whether it ends the frame.
    logic [13:0] next_row;
    logic [13:0] next_col;
    logic        frame_end;
    always_comb begin
        next_row  = row;
        next_col  = col + 14'(BURST_LEN);
        frame_end = 1'b0;
        if (next_col == 14'(VIDEO_WIDTH)) begin
            next_col  = '0;
            next_row  = row + 14'd1;
            frame_end = (next_row == 14'(VIDEO_HEIGHT));
        end
    end

    // Source mapping for the burst about to be launched. In LATCH this burst
    // is the first one of the frame, so the live inputs are used, because the
    // latched copies are not loaded yet. In NEXT it is the following burst.
    logic [2:0]         ev_mode;
    logic signed [13:0] ev_xs, ev_ys, ev_r, ev_c, src_row, src_col;
    logic               in_range;
    always_comb begin
        ev_mode = mode_lat;
        ev_xs   = xs_lat;
        ev_ys   = ys_lat;
        ev_r    = next_row;
        ev_c    = next_col;
        if (state == LATCH) begin
            ev_mode = mode_in;
            ev_xs   = xs_in;
            ev_ys   = ys_in;
            ev_r    = '0;
            ev_c    = '0;
        end
        src_row = ev_r;
        src_col = ev_c;
        case (ev_mode)
            3'd1:    src_col = ev_c - ev_xs;
            3'd2:    src_row = ev_r - ev_ys;
            3'd3:    src_col = W_S - B_S - ev_c;
            3'd4:    src_row = H_S - 14'sd1 - ev_r;
            default: ;
        endcase
        in_range = (src_row >= 14'sd0) && (src_row < H_S) &&
                   (src_col >= 14'sd0) && (src_col < W_S);
    end

    // Buffer addresses. Flag 0 reads from buffer A and writes to buffer B.
    // Flag 1 does the opposite.
    logic [ADDR_LEN-1:0] ch_base, src_base, dst_base, rd_addr_next, wr_addr_next;
    logic [2:0]          next_ch;
    always_comb begin
        ch_base      = ADDR_LEN'(CH_BASE) + ADDR_LEN'(cur_ch) * ADDR_LEN'(CH_STRIDE);
        src_base     = ping[cur_ch] ? ch_base + ADDR_LEN'(CH_STRIDE / 2) : ch_base;
        dst_base     = ping[cur_ch] ? ch_base : ch_base + ADDR_LEN'(CH_STRIDE / 2);
        rd_addr_next = src_base + ADDR_LEN'(src_row) * ADDR_LEN'(VIDEO_WIDTH)
                     + ADDR_LEN'(src_col);
        wr_addr_next = dst_base + ADDR_LEN'(row) * ADDR_LEN'(VIDEO_WIDTH)
                     + ADDR_LEN'(col);
        next_ch      = (cur_ch == 3'(N_CH - 1)) ? 3'd0 : cur_ch + 3'd1;
    end

    // Next word to present on wr_data. The first word is loaded when wr_valid
    // rises. Each later word is loaded when wr_data_req consumes the current one.
    logic [IDX_W-1:0]        load_idx;
    logic [IDX_W-1:0]        buf_idx;
    logic [MEM_DATA_LEN-1:0] load_word;
`ifdef IMG_XFORM_BORDER_EN
    localparam logic [MEM_DATA_LEN-1:0] BORDER_WORD = {(MEM_DATA_LEN / 16){16'hFFFF}};
    logic [13:0] out_col;
`endif
    always_comb begin
        load_idx  = wr_valid ? idx + IDX_W'(1) : '0;
        buf_idx   = (mode_lat == 3'd3) ? IDX_W'(BURST_LEN - 1) - load_idx : load_idx;
        load_word = skip_burst ? FILL_COLOR : buffer[buf_idx];
`ifdef IMG_XFORM_BORDER_EN
        out_col = col + 14'(load_idx);
        if (row == 14'd0 || row == 14'(VIDEO_HEIGHT - 1) ||
            out_col == 14'd0 || out_col == 14'(VIDEO_WIDTH - 1)) begin
            load_word = BORDER_WORD;
        end
`endif
    end

    // Local burst buffer. It has no reset. Slots that a short burst does not
    // fill keep their old contents.
    always_ff @(posedge clk) begin
        if (state == READ && rd_data_valid && rd_cnt < CNT_W'(BURST_LEN)) begin
            buffer[rd_cnt[IDX_W-1:0]] <= rd_data;
        end
    end

    // Main control FSM. All interface outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_lat   <= '0;
            xs_lat     <= '0;
            ys_lat     <= '0;
            row        <= '0;
            col        <= '0;
            ping       <= '0;
            cur_ch     <= '0;
            skip_burst <= 1'b0;
            rd_cnt     <= '0;
            idx        <= '0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if ((rd_burst_finish && state != READ) || (wr_burst_finish && state != WRITE)) begin
                error <= 1'b1;
            end
            case (state)
                IDLE: state <= LATCH;
                LATCH, NEXT: begin
                    if (state == NEXT && frame_end) begin
                        frame_done   <= 1'b1;
                        ping[cur_ch] <= ~ping[cur_ch];
                        cur_ch       <= next_ch;
                        state        <= IDLE;
                    end else begin
                        if (state == LATCH) begin
                            mode_lat <= mode_in;
                            xs_lat   <= xs_in;
                            ys_lat   <= ys_in;
                            row      <= '0;
                            col      <= '0;
                        end else begin
                            row <= next_row;
                            col <= next_col;
                        end
                        skip_burst <= !in_range;
                        rd_cnt     <= '0;
                        if (in_range) begin
                            rd_valid <= 1'b1;
                            rd_addr  <= rd_addr_next;
                            state    <= READ;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                READ: begin
                    if (rd_data_valid && rd_cnt != '1) begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                    if (rd_burst_finish) begin
                        rd_valid <= 1'b0;
                        state    <= WRITE;
                        if (rd_cnt + CNT_W'(rd_data_valid) != CNT_W'(BURST_LEN)) begin
                            error <= 1'b1;
                        end
                    end
                end
                SKIP: state <= WRITE;
                WRITE: begin
                    if (!wr_valid) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= wr_addr_next;
                        wr_data  <= load_word;
                        idx      <= '0;
                    end else if (wr_burst_finish) begin
                        wr_valid <= 1'b0;
                        state    <= NEXT;
                    end else if (wr_data_req) begin
                        idx     <= load_idx;
                        wr_data <= load_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_xform_engine.sv
// ----------------------------------------------------------------------------
// tb_image_xform_engine
//
// Self-checking bench for image_xform_engine on a small 16x4 frame with 8-word
// bursts and two channels. A behavioural memory serves read bursts and accepts
// write bursts. Each source buffer is filled with random words before its frame.
// The destination buffer is then compared word-by-word against a per-pixel
// reference mapping. Also covers read counts, frame_done, channel rotation,
// the sticky error flag, and reset in the middle of a write.
// Honours IMG_XFORM_BORDER_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_image_xform_engine;

    localparam int W = 16;
    localparam int H = 4;
    localparam int B = 8;
    localparam int STRIDE = 256;
    localparam int NF = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  mode = '0;
    logic [11:0] x_shift = '0;
    logic [11:0] y_shift = '0;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [9:0]  rd_burst_len;
    logic        rd_data_valid = 1'b0;
    logic [63:0] rd_data = '0;
    logic        rd_burst_finish = 1'b0;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [9:0]  wr_burst_len;
    logic        wr_data_req = 1'b0;
    logic [63:0] wr_data;
    logic        wbf_slave = 1'b0;
    logic        wbf_stray = 1'b0;
    logic [2:0]  cur_ch;
    logic        frame_done;
    logic        error;

    image_xform_engine #(
        .MEM_DATA_LEN(64), .ADDR_LEN(32), .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H),
        .BURST_LEN(B), .N_CH(2), .CH_BASE(0), .CH_STRIDE(STRIDE), .FILL_COLOR(64'h0)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .x_shift(x_shift), .y_shift(y_shift),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_burst_finish(rd_burst_finish),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_burst_len(wr_burst_len),
        .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_burst_finish(wbf_slave | wbf_stray),
        .cur_ch(cur_ch), .frame_done(frame_done), .error(error)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [2 * STRIDE];
    logic [63:0] exp_word [W * H];
    int tests_run = 0;
    int failures = 0;
    int read_cnt = 0, write_cnt = 0, done_cnt = 0, overlap = 0;
    int exp_reads = 0, cur_dst = 0;
    int model_ch = 0;
    bit model_flag [2] = '{1'b0, 1'b0};

    // Every comparison goes through here: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic finishBench();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    endtask

    // Memory read slave. Starts a burst when rd_valid is seen, waits a short
    // latency, and streams B words with random gaps. It then pulses
    // rd_burst_finish, and drops back to idle once rd_valid is gone.
    int rs_addr, rs_cnt, rs_delay;
    bit rs_busy = 0, rs_fin = 0;
    always @(negedge clk) begin
        rd_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        if (!rst) begin
            rs_busy = 0;
        end else if (!rs_busy) begin
            if (rd_valid) begin
                rs_busy = 1; rs_fin = 0; rs_cnt = 0; rs_delay = 2;
                rs_addr = int'(rd_addr);
                read_cnt++;
            end
        end else if (rs_delay > 0) begin
            rs_delay--;
        end else if (rs_cnt < B) begin
            if ($urandom_range(0, 3) != 0) begin
                rd_data_valid = 1'b1;
                rd_data = (rs_addr + rs_cnt < 2 * STRIDE) ? mem[rs_addr + rs_cnt] : 64'h0;
                rs_cnt++;
            end
        end else if (!rs_fin) begin
            rd_burst_finish = 1'b1;
            rs_fin = 1;
        end else begin
            rs_busy = 0;
        end
    end

    // Memory write slave. Requests B words with random gaps, storing whatever
    // wr_data shows when each request is raised, and then pulses
    // wr_burst_finish.
    int ws_addr, ws_cnt, ws_delay;
    bit ws_busy = 0, ws_fin = 0;
    always @(negedge clk) begin
        wr_data_req = 1'b0;
        wbf_slave = 1'b0;
        if (!rst) begin
            ws_busy = 0;
        end else if (!ws_busy) begin
            if (wr_valid) begin
                ws_busy = 1; ws_fin = 0; ws_cnt = 0; ws_delay = 1;
                ws_addr = int'(wr_addr);
                write_cnt++;
            end
        end else if (ws_delay > 0) begin
            ws_delay--;
        end else if (ws_cnt < B) begin
            if ($urandom_range(0, 3) != 0) begin
                if (ws_addr + ws_cnt < 2 * STRIDE) mem[ws_addr + ws_cnt] = wr_data;
                wr_data_req = 1'b1;
                ws_cnt++;
            end
        end else if (!ws_fin) begin
            wbf_slave = 1'b1;
            ws_fin = 1;
        end else begin
            ws_busy = 0;
        end
    end

    // Track frame_done pulses, and any cycle where both request lines are high.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (rd_valid && wr_valid) overlap++;
    end

    task automatic applyStimulus(input int m, input int xs, input int ys);
        mode = 3'(m);
        x_shift = 12'(xs);
        y_shift = 12'(ys);
    endtask

    // Fill the next source buffer with random data and poison the destination.
    // Build the expected destination image pixel by pixel, then drive the
    // frame's inputs.
    task automatic setupFrame(input int m, input int xs, input int ys);
        int src, em, xe, sr, sc;
        bit inr;
        src = model_ch * STRIDE + (model_flag[model_ch] ? STRIDE / 2 : 0);
        cur_dst = model_ch * STRIDE + (model_flag[model_ch] ? 0 : STRIDE / 2);
        for (int i = 0; i < W * H; i++) begin
            mem[src + i] = {$urandom, $urandom};
            mem[cur_dst + i] = {$urandom, $urandom};
        end
        em = (m > 4) ? 0 : m;
        xe = xs & ~(B - 1);
        exp_reads = 0;
        for (int r = 0; r < H; r++) begin
            for (int j = 0; j < W; j++) begin
                sr = r; sc = j;
                case (em)
                    1: sc = j - xe;
                    2: sr = r - ys;
                    3: sc = W - 1 - j;
                    4: sr = H - 1 - r;
                    default: ;
                endcase
                inr = (sr >= 0) && (sr < H) && (sc >= 0) && (sc < W);
                exp_word[r * W + j] = inr ? mem[src + sr * W + sc] : 64'h0;
`ifdef IMG_XFORM_BORDER_EN
                if (r == 0 || r == H - 1 || j == 0 || j == W - 1) exp_word[r * W + j] = '1;
`endif
                if (j % B == 0 && inr) exp_reads++;
            end
        end
        read_cnt = 0; write_cnt = 0; done_cnt = 0;
        applyStimulus(m, xs, ys);
    endtask

    task automatic waitFrame(input bit mid_change, output bit ok);
        ok = 0;
        for (int cyc = 0; cyc < 4000 && !ok; cyc++) begin
            @(negedge clk); #1;
            if (mid_change && cyc == 60) applyStimulus(3, 8, 2);
            if (frame_done) ok = 1;
        end
    endtask

    task automatic checkFrame();
        for (int i = 0; i < W * H; i++) checkOutput($sformatf("dst[%0d]", i), mem[cur_dst + i], exp_word[i]);
        checkOutput("reads", 64'(read_cnt), 64'(exp_reads));
        checkOutput("writes", 64'(write_cnt), 64'(W * H / B));
        checkOutput("frame_done count", 64'(done_cnt), 64'd1);
        model_flag[model_ch] = ~model_flag[model_ch];
        model_ch = (model_ch + 1) % 2;
        checkOutput("cur_ch", 64'(cur_ch), 64'(model_ch));
        checkOutput("error", 64'(error), 64'd0);
        checkOutput("rd/wr overlap", 64'(overlap), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
        checkOutput({tag, " wr_valid"}, 64'(wr_valid), 64'd0);
        checkOutput({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
        checkOutput({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
        checkOutput({tag, " wr_data"}, wr_data, 64'd0);
        checkOutput({tag, " cur_ch"}, 64'(cur_ch), 64'd0);
        checkOutput({tag, " frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({tag, " error"}, 64'(error), 64'd0);
        checkOutput({tag, " rd_burst_len"}, 64'(rd_burst_len), 64'(B));
        checkOutput({tag, " wr_burst_len"}, 64'(wr_burst_len), 64'(B));
    endtask

    // Directed frames first, then random ones. Frame 3 is the YSHIFT -1 frame
    // whose inputs change part-way through.
    int f_mode [NF] = '{0, 1, 3, 2, 4, 6, 1, 1, 0, 0, 0, 0, 0, 0};
    int f_xs   [NF] = '{0, 8, 0, 0, 0, 5, -8, 13, 0, 0, 0, 0, 0, 0};
    int f_ys   [NF] = '{0, 0, 0, -1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        bit ok;
        for (int k = 8; k < NF; k++) begin
            f_mode[k] = int'($urandom_range(0, 7));
            f_xs[k]   = int'($urandom_range(0, 48)) - 24;
            f_ys[k]   = int'($urandom_range(0, 8)) - 4;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkResetState("reset");

        setupFrame(f_mode[0], f_xs[0], f_ys[0]);
        rst = 1'b1;
        for (int k = 0; k < NF; k++) begin
            waitFrame(k == 3, ok);
            if (!ok) begin
                checkOutput("frame timeout", 64'd0, 64'd1);
                finishBench();
            end
            checkFrame();
            if (k < NF - 1) setupFrame(f_mode[k + 1], f_xs[k + 1], f_ys[k + 1]);
            else setupFrame(0, 0, 0);
        end

        // A wr_burst_finish arriving while a read is in flight must set the
        // sticky error flag.
        ok = 0;
        for (int cyc = 0; cyc < 400 && !ok; cyc++) begin
            @(negedge clk); #1;
            if (rd_valid) ok = 1;
        end
        checkOutput("read seen for stray test", 64'(ok), 64'd1);
        wbf_stray = 1'b1;
        @(negedge clk); #1;
        wbf_stray = 1'b0;
        checkOutput("error after stray", 64'(error), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("error sticky", 64'(error), 64'd1);

        // Pull reset in the middle of a write burst.
        ok = 0;
        for (int cyc = 0; cyc < 400 && !ok; cyc++) begin
            @(negedge clk); #1;
            if (wr_valid) ok = 1;
        end
        checkOutput("write seen for reset test", 64'(ok), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        checkResetState("mid-write reset");

        // After reset, start again on channel 0 with all ping-pong flags at zero.
        model_ch = 0;
        model_flag = '{1'b0, 1'b0};
        overlap = 0;
        setupFrame(0, 0, 0);
        rst = 1'b1;
        waitFrame(1'b0, ok);
        if (!ok) begin
            checkOutput("frame timeout", 64'd0, 64'd1);
            finishBench();
        end
        checkFrame();
        finishBench();
    end

endmodule
